// File: rtl/regs_mp_pkg.sv
// Shared definitions for the regs_mp register file: default widths,
// NZCV flag bit positions and the selector range check.
package regs_mp_pkg;

  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_NUM_REGS = 15;
  localparam int unsigned DEF_SEL_W    = 4;
  localparam int unsigned DEF_NUM_RD   = 2;
  localparam int unsigned DEF_NUM_WR   = 2;
  localparam int unsigned DEF_FLAG_W   = 4;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // True when a selector addresses an implemented architectural register
  function automatic logic sel_in_range(input int unsigned sel, input int unsigned num_regs);
    return (sel < num_regs);
  endfunction

endpackage

// File: rtl/regs_mp_wr_arb.sv
// Write-port arbiter: folds NUM_WR write requests into one write enable and
// one data word per register; the highest-index port wins on a collision.
module regs_mp_wr_arb
  import regs_mp_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned SEL_W    = DEF_SEL_W,
  parameter int unsigned NUM_WR   = DEF_NUM_WR
) (
  input  logic                             i_enable,
  input  logic [NUM_WR-1:0]                i_wr_en,
  input  logic [NUM_WR-1:0][SEL_W-1:0]     i_wr_sel,
  input  logic [NUM_WR-1:0][DATA_W-1:0]    i_wr_data,
  output logic [NUM_REGS-1:0]              o_we_c,
  output logic [NUM_REGS-1:0][DATA_W-1:0]  o_wdata_c
);

  // Ascending port scan so a later (higher-index) port overrides earlier ones
  always_comb begin
    o_we_c    = '0;
    o_wdata_c = '0;
    for (int k = 0; k < int'(NUM_WR); k++) begin
      if (i_enable && i_wr_en[k] && sel_in_range(32'(i_wr_sel[k]), NUM_REGS)) begin
        for (int r = 0; r < int'(NUM_REGS); r++) begin
          if (i_wr_sel[k] == SEL_W'(r)) begin
            o_we_c[r]    = 1'b1;
            o_wdata_c[r] = i_wr_data[k];
          end
        end
      end
    end
  end

endmodule

// File: rtl/regs_mp.sv
// regs_mp: multi-port architectural register file (r0..r14) with NZCV flag
// register and a pending-write reservation scoreboard. Reads are registered.
// Optional feature: define REGS_MP_BYPASS_EN to forward same-cycle writes,
// reservations and flag updates into the registered read outputs.
module regs_mp
  import regs_mp_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned SEL_W    = DEF_SEL_W,
  parameter int unsigned NUM_RD   = DEF_NUM_RD,
  parameter int unsigned NUM_WR   = DEF_NUM_WR,
  parameter int unsigned FLAG_W   = DEF_FLAG_W
) (
  input  logic                           clock,
  input  logic                           not_reset,
  input  logic                           not_enable,
  input  logic [NUM_WR-1:0]              wr_en,
  input  logic [NUM_WR-1:0][SEL_W-1:0]   wr_sel,
  input  logic [NUM_WR-1:0][DATA_W-1:0]  wr_data,
  input  logic [NUM_RD-1:0][SEL_W-1:0]   rd_sel,
  output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data,
  output logic [NUM_RD-1:0]              rd_busy,
  input  logic [FLAG_W-1:0]              in_flags,
  input  logic [FLAG_W-1:0]              flags_we,
  output logic [FLAG_W-1:0]              out_flags,
  input  logic                           rsv_en,
  input  logic [SEL_W-1:0]               rsv_sel,
  output logic [NUM_REGS-1:0]            pending
);

  logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;
  logic [NUM_REGS-1:0]             r_pending;
  logic [FLAG_W-1:0]               r_flags;
  logic [NUM_RD-1:0][DATA_W-1:0]   r_rd_data;
  logic [NUM_RD-1:0]               r_rd_busy;
  logic [FLAG_W-1:0]               r_out_flags;

  logic [NUM_REGS-1:0]             w_we;
  logic [NUM_REGS-1:0][DATA_W-1:0] w_wdata;
  logic [NUM_REGS-1:0][DATA_W-1:0] w_regs_nxt;
  logic [NUM_REGS-1:0]             w_pending_nxt;
  logic [FLAG_W-1:0]               w_flags_nxt;
  logic                            w_rsv_ok;
  logic [NUM_REGS-1:0][DATA_W-1:0] w_rd_src;
  logic [NUM_REGS-1:0]             w_busy_src;
  logic [FLAG_W-1:0]               w_flags_src;
  logic [NUM_RD-1:0][DATA_W-1:0]   w_rd_data;
  logic [NUM_RD-1:0]               w_rd_busy;

  regs_mp_wr_arb #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .SEL_W    (SEL_W),
    .NUM_WR   (NUM_WR)
  ) u_wr_arb (
    .i_enable  (!not_enable),
    .i_wr_en   (wr_en),
    .i_wr_sel  (wr_sel),
    .i_wr_data (wr_data),
    .o_we_c    (w_we),
    .o_wdata_c (w_wdata)
  );

  assign w_rsv_ok = rsv_en && !not_enable && sel_in_range(32'(rsv_sel), NUM_REGS);

  // Next register/pending state; a reservation beats a same-cycle write clear
  always_comb begin
    w_regs_nxt    = r_regs;
    w_pending_nxt = r_pending;
    for (int r = 0; r < int'(NUM_REGS); r++) begin
      if (w_we[r]) begin
        w_regs_nxt[r]    = w_wdata[r];
        w_pending_nxt[r] = 1'b0;
      end
      if (w_rsv_ok && (rsv_sel == SEL_W'(r))) begin
        w_pending_nxt[r] = 1'b1;
      end
    end
  end

  // Per-bit masked flag update, frozen by not_enable
  assign w_flags_nxt = not_enable ? r_flags
                                  : ((r_flags & ~flags_we) | (in_flags & flags_we));

`ifdef REGS_MP_BYPASS_EN
  assign w_rd_src    = w_regs_nxt;
  assign w_busy_src  = w_pending_nxt;
  assign w_flags_src = w_flags_nxt;
`else
  assign w_rd_src    = r_regs;
  assign w_busy_src  = r_pending;
  assign w_flags_src = r_flags;
`endif

  // Read mux; selectors beyond the last register match nothing and read 0
  always_comb begin
    w_rd_data = '0;
    w_rd_busy = '0;
    for (int i = 0; i < int'(NUM_RD); i++) begin
      for (int r = 0; r < int'(NUM_REGS); r++) begin
        if (rd_sel[i] == SEL_W'(r)) begin
          w_rd_data[i] = w_rd_src[r];
          w_rd_busy[i] = w_busy_src[r];
        end
      end
    end
  end

  // All state and registered outputs, cleared asynchronously on reset
  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      r_regs      <= '0;
      r_pending   <= '0;
      r_flags     <= '0;
      r_rd_data   <= '0;
      r_rd_busy   <= '0;
      r_out_flags <= '0;
    end else begin
      r_regs      <= w_regs_nxt;
      r_pending   <= w_pending_nxt;
      r_flags     <= w_flags_nxt;
      r_rd_data   <= w_rd_data;
      r_rd_busy   <= w_rd_busy;
      r_out_flags <= w_flags_src;
    end
  end

  assign rd_data   = r_rd_data;
  assign rd_busy   = r_rd_busy;
  assign out_flags = r_out_flags;
  assign pending   = r_pending;

endmodule

// File: doc/regs_mp.md
REGS_MP -- requirements
Module: regs_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register and data width.
REQ-002 SHALL have parameter NUM_REGS, default 15, architectural registers r0..r14; PC is held outside this block.
REQ-003 SHALL have parameter SEL_W, default 4, selector width; legal only if 2**SEL_W >= NUM_REGS.
REQ-004 SHALL have parameters NUM_RD, default 2, and NUM_WR, default 2: read-port and write-port counts.
REQ-005 SHALL have parameter FLAG_W, default 4, flag register width (NZCV).
REQ-006 SHALL have port clock  in  1  single clock, all state on rising edge.
REQ-007 SHALL have port not_reset  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port not_enable  in  1  when high: freezes writes, flag updates and reservations; reads continue.
REQ-009 SHALL have ports wr_en  in  NUM_WR, wr_sel  in  NUM_WR x SEL_W, wr_data  in  NUM_WR x DATA_W: per-port write request, target, data.
REQ-010 SHALL have ports rd_sel  in  NUM_RD x SEL_W and rd_data  out  NUM_RD x DATA_W: registered read ports.
REQ-011 SHALL have port rd_busy  out  NUM_RD  selected register has a pending reservation (registered with rd_data).
REQ-012 SHALL have ports in_flags  in  FLAG_W, flags_we  in  FLAG_W (per-bit update mask), out_flags  out  FLAG_W.
REQ-013 SHALL have ports rsv_en  in  1 and rsv_sel  in  SEL_W: reserve register as pending-write target.
REQ-014 SHALL have port pending  out  NUM_REGS  current reservation bitmap.

Function
REQ-015 Reads SHALL have 1-cycle latency: rd_data[i], rd_busy[i] sampled from rd_sel[i] at rising edge, valid after that edge.
REQ-016 Out-of-range selector (>= NUM_REGS) SHALL read 0 with rd_busy 0, and write or reserve SHALL be ignored.
REQ-017 Write SHALL occur at rising edge when wr_en[k]=1 and not_enable=0.
REQ-018 Two ports writing the same register in one cycle SHALL resolve to the highest-index port.
REQ-019 Flag bit j SHALL update to in_flags[j] only when flags_we[j]=1 and not_enable=0; other bits hold.
REQ-020 out_flags SHALL be registered, reflecting the flag register after the prior edge (1-cycle latency).
REQ-021 rsv_en=1, not_enable=0 SHALL set pending[rsv_sel]; any committed write to a register SHALL clear its pending bit.
REQ-022 Reservation and write to the same register in one cycle SHALL leave pending set (reservation wins); data is still written.
REQ-023 Read of a register written in the same cycle SHALL return the old value (no bypass) unless REQ-028 applies.

Reset
REQ-024 not_reset low SHALL immediately clear all registers, flags, pending, rd_data, rd_busy and out_flags to 0, regardless of clock.
REQ-025 Reset deassertion mid-operation SHALL discard any write or reservation presented in the reset cycle; first effective edge is the first rising edge with not_reset high.

Configuration
REQ-026 Macro REGS_MP_BYPASS_EN SHALL select same-cycle write-to-read forwarding.
REQ-027 Without REGS_MP_BYPASS_EN, behaviour SHALL follow REQ-023.
REQ-028 With REGS_MP_BYPASS_EN, rd_data SHALL capture the data being written to the selected register in that cycle (highest-index port per REQ-018), rd_busy SHALL reflect the post-edge pending value, and out_flags SHALL reflect masked new flags.

Structure
REQ-029 Shared package regs_mp_pkg SHALL hold default widths, flag bit indices (N=3, Z=2, C=1, V=0) and the selector-range check function.
REQ-030 Write-port priority resolution SHALL be one sub-module, regs_mp_wr_arb, producing per-register write enable and data.

Verification
REQ-031 Reset: write r3=0xDEADBEEF, pulse not_reset low mid-cycle -> r3, flags, pending, rd_data read 0 immediately.
REQ-032 Conflict: wr0 r5=0x11, wr1 r5=0x22 same cycle -> next read r5 = 0x22.
REQ-033 Flags: flags=0xF, in_flags=0x0, flags_we=0x4 -> out_flags=0xB.
REQ-034 Scoreboard: reserve r7 -> rd_busy=1 reading r7; write r7=0x5 -> pending[7]=0; reserve+write r7 same cycle -> pending[7]=1.
REQ-035 Freeze/range: not_enable=1 with writes and reserve -> no state change; wr_sel=15 with NUM_REGS=15 -> ignored, read r15 = 0.
REQ-036 Bypass: write r2=0x1234 while reading r2 (old 0) -> rd_data 0 without macro, 0x1234 with REGS_MP_BYPASS_EN.
